// File: rtl/lcd_read_fsm.sv
// lcd_read_fsm: one HD44780-style 4-bit read (two E strobes, upper then lower nibble) into a byte.
// Define LCD_BUSY_POLL_EN to repeat busy-flag reads until BF=0 or POLL_LIMIT attempts.
`timescale 1ns/1ps
module lcd_read_fsm #(
  parameter int SETUP_CYCLES  = 5,
  parameter int E_HIGH_CYCLES = 14,
  parameter int NIBBLE_GAP    = 50,
  parameter int HOLD_CYCLES   = 2,
  parameter int POLL_LIMIT    = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic       rs_sel,
  input  logic [3:0] sf_d_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       sf_ce0,
  output logic       sf_d_oe,
  output logic       ready,
  output logic       valid,
  output logic [7:0] data_out,
  output logic       busy_flag,
  output logic [6:0] addr,
  output logic       poll_timeout
);

`ifdef LCD_BUSY_POLL_EN
  localparam logic POLL_EN = 1'b1;
`else
  localparam logic POLL_EN = 1'b0;
`endif

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] E_LAST     = 16'(E_HIGH_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(NIBBLE_GAP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] POLL_LAST  = 16'(POLL_LIMIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_UPPER_E = 3'd2,
    ST_GAP     = 3'd3,
    ST_LOWER_E = 3'd4,
    ST_HOLD    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] cnt_r;
  logic [15:0] attempt_r;
  logic [7:0]  hold_r;
  logic        rs_lat_r;
  logic        rs_cur_s;
  logic        repoll_s;
  logic        timeout_s;
  logic        illegal_s;
  logic        e_s;
  logic        rs_s;
  logic        rw_s;
  logic        oe_s;
  logic        ready_s;

  assign sf_ce0    = 1'b0;
  assign busy_flag = data_out[7];
  assign addr      = data_out[6:0];

  // Next-state logic; a busy read under polling loops back to SETUP instead of finishing.
  always_comb begin
    next_state_s = ST_IDLE;
    illegal_s    = 1'b0;
    timeout_s    = POLL_EN && !rs_lat_r && hold_r[7];
    repoll_s     = timeout_s && (attempt_r < POLL_LAST);
    case (state_r)
      ST_IDLE:    next_state_s = start ? ST_SETUP : ST_IDLE;
      ST_SETUP:   next_state_s = (cnt_r == SETUP_LAST) ? ST_UPPER_E : ST_SETUP;
      ST_UPPER_E: next_state_s = (cnt_r == E_LAST) ? ST_GAP : ST_UPPER_E;
      ST_GAP:     next_state_s = (cnt_r == GAP_LAST) ? ST_LOWER_E : ST_GAP;
      ST_LOWER_E: next_state_s = (cnt_r == E_LAST) ? ST_HOLD : ST_LOWER_E;
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          next_state_s = repoll_s ? ST_SETUP : ST_DONE;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      ST_DONE:    next_state_s = ST_IDLE;
      default: begin
        next_state_s = ST_IDLE;
        illegal_s    = 1'b1;
      end
    endcase
  end

  // Bus pin values for the state being entered, so the pins change on the same edge as the state.
  always_comb begin
    rs_cur_s = (state_r == ST_IDLE) ? rs_sel : rs_lat_r;
    e_s      = 1'b0;
    rs_s     = 1'b0;
    rw_s     = 1'b0;
    oe_s     = 1'b1;
    ready_s  = 1'b0;
    case (next_state_s)
      ST_IDLE: ready_s = 1'b1;
      ST_SETUP, ST_GAP, ST_HOLD: begin
        rw_s = 1'b1;
        rs_s = rs_cur_s;
        oe_s = 1'b0;
      end
      ST_UPPER_E, ST_LOWER_E: begin
        e_s  = 1'b1;
        rw_s = 1'b1;
        rs_s = rs_cur_s;
        oe_s = 1'b0;
      end
      ST_DONE: ready_s = 1'b0;
      default: ready_s = 1'b1;
    endcase
  end

  // State register and phase counter; enable low aborts exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_r <= ST_IDLE;
      cnt_r   <= 16'd0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= (next_state_s != state_r || state_r == ST_IDLE) ? 16'd0 : cnt_r + 16'd1;
    end
  end

  // Nibble capture, attempt count and registered outputs.
  always_ff @(posedge clk) begin
    if (reset || !enable || illegal_s) begin
      rs_lat_r     <= 1'b0;
      attempt_r    <= 16'd0;
      hold_r       <= 8'h00;
      lcd_e        <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_rw       <= 1'b0;
      sf_d_oe      <= 1'b1;
      ready        <= 1'b1;
      valid        <= 1'b0;
      data_out     <= 8'h00;
      poll_timeout <= 1'b0;
    end else begin
      lcd_e        <= e_s;
      lcd_rs       <= rs_s;
      lcd_rw       <= rw_s;
      sf_d_oe      <= oe_s;
      ready        <= ready_s;
      valid        <= (next_state_s == ST_DONE);
      poll_timeout <= (next_state_s == ST_DONE) && timeout_s;
      if (state_r == ST_IDLE && start) begin
        rs_lat_r  <= rs_sel;
        attempt_r <= 16'd0;
      end else if (state_r == ST_HOLD && next_state_s == ST_SETUP) begin
        attempt_r <= attempt_r + 16'd1;
      end
      // The LCD drives sf_d while E is high; sample on the last high cycle of each strobe.
      if (state_r == ST_UPPER_E && cnt_r == E_LAST) begin
        hold_r[7:4] <= sf_d_in;
      end
      if (state_r == ST_LOWER_E && cnt_r == E_LAST) begin
        hold_r[3:0] <= sf_d_in;
      end
      if (next_state_s == ST_DONE) begin
        data_out <= hold_r;
      end
    end
  end

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Bench for lcd_read_fsm: directed reads plus random stimulus, checked every cycle
// against a timeline model that derives the pins from the offset since the accepting edge.
`timescale 1ns/1ps
module tb_lcd_read_fsm;
  localparam int SETUP    = 5;
  localparam int EH       = 14;
  localparam int GAP      = 50;
  localparam int HOLD     = 2;
  localparam int LIMIT    = 100;
  localparam int U_FIRST  = SETUP + 1;
  localparam int U_LAST   = SETUP + EH;
  localparam int L_FIRST  = SETUP + EH + GAP + 1;
  localparam int L_LAST   = SETUP + 2 * EH + GAP;
  localparam int DONE_OFF = L_LAST + HOLD + 1;
`ifdef LCD_BUSY_POLL_EN
  localparam bit POLL_EN = 1'b1;
`else
  localparam bit POLL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, enable, start, rs_sel;
  logic [3:0] sf_d_in;
  logic       lcd_e, lcd_rs, lcd_rw, sf_ce0, sf_d_oe, ready, valid, busy_flag, poll_timeout;
  logic [7:0] data_out;
  logic [6:0] addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // timeline model state
  bit         m_act = 1'b0;
  int         m_off = 0;
  int         m_att = 0;
  bit         m_rs  = 1'b0;
  bit         m_to  = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_data = 8'h00;

  logic [3:0] up_seq [4];
  logic [3:0] lo_n;
  bit         rand_nib = 1'b0;

  bit          in_tx, x_e, x_rs, x_rw, x_oe, x_rdy, x_vld, x_to;
  logic [23:0] exp_v, got_v;

  lcd_read_fsm #(
    .SETUP_CYCLES(SETUP), .E_HIGH_CYCLES(EH), .NIBBLE_GAP(GAP),
    .HOLD_CYCLES(HOLD), .POLL_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .rs_sel(rs_sel),
    .sf_d_in(sf_d_in), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .sf_ce0(sf_ce0),
    .sf_d_oe(sf_d_oe), .ready(ready), .valid(valid), .data_out(data_out),
    .busy_flag(busy_flag), .addr(addr), .poll_timeout(poll_timeout)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: advance the transaction offset on every edge.
  initial forever begin
    @(posedge clk);
    if (reset || !enable) begin
      m_act = 1'b0; m_off = 0; m_data = 8'h00; m_to = 1'b0;
    end else if (!m_act) begin
      m_to = 1'b0;
      if (start) begin
        m_act = 1'b1; m_off = 1; m_rs = rs_sel; m_att = 0;
      end
    end else begin
      if (m_off == U_LAST) m_byte[7:4] = sf_d_in;
      if (m_off == L_LAST) m_byte[3:0] = sf_d_in;
      if (m_off == DONE_OFF) begin
        m_act = 1'b0; m_to = 1'b0;
      end else if (m_off == DONE_OFF - 1 && POLL_EN && !m_rs && m_byte[7] && m_att + 1 < LIMIT) begin
        m_att = m_att + 1; m_off = 1;
      end else begin
        m_off = m_off + 1;
        if (m_off == DONE_OFF) begin
          m_data = m_byte;
          m_to   = POLL_EN && !m_rs && m_byte[7];
        end
      end
    end
  end

  // LCD side: hold a nibble while E is high, random noise otherwise.
  initial forever begin
    int idx;
    @(posedge clk); #1;
    if (rand_nib && m_act && m_off == 1) begin
      for (int k = 0; k < 4; k++) up_seq[k] = 4'($urandom);
      lo_n = 4'($urandom);
    end
    idx = (m_att > 3) ? 3 : m_att;
    if (m_act && m_off >= U_FIRST && m_off <= U_LAST) sf_d_in = up_seq[idx];
    else if (m_act && m_off >= L_FIRST && m_off <= L_LAST) sf_d_in = lo_n;
    else sf_d_in = 4'($urandom);
  end

  // Compare every output against the model on each falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (m_act) begin
        in_tx = (m_off < DONE_OFF);
        x_e   = (m_off >= U_FIRST && m_off <= U_LAST) || (m_off >= L_FIRST && m_off <= L_LAST);
        x_rw  = in_tx;
        x_rs  = in_tx && m_rs;
        x_oe  = !in_tx;
        x_rdy = 1'b0;
        x_vld = !in_tx;
        x_to  = !in_tx && m_to;
      end else begin
        x_e = 1'b0; x_rs = 1'b0; x_rw = 1'b0; x_oe = 1'b1; x_rdy = 1'b1; x_vld = 1'b0; x_to = 1'b0;
      end
      exp_v = {x_e, x_rs, x_rw, 1'b0, x_oe, x_rdy, x_vld, x_to, m_data, m_data[7], m_data[6:0]};
      got_v = {lcd_e, lcd_rs, lcd_rw, sf_ce0, sf_d_oe, ready, valid, poll_timeout,
               data_out, busy_flag, addr};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL outputs cyc=%0d got=%h expected=%h (e,rs,rw,ce0,oe,rdy,vld,to|data|bf,addr)",
                 cyc, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_read(input logic rs);
    start = 1'b1; rs_sel = rs;
    step();
    start = 1'b0; rs_sel = 1'($urandom);
  endtask

  task automatic wait_valid(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat, nv, v1, v2;
    int edges[$];
    logic prev_e;
    logic [7:0] got_byte;
    logic got_bf;
    logic [6:0] got_addr;
    reset = 1'b1; enable = 1'b1; start = 1'b0; rs_sel = 1'b0; sf_d_in = 4'h0;
    up_seq = '{4'h0, 4'h0, 4'h0, 4'h0}; lo_n = 4'h0;
    step(); step();
    reset = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_data", data_out, 0);
    chk("rst_rw", lcd_rw, 0);
    step();

    // data read 4,1
    up_seq = '{4'h4, 4'h4, 4'h4, 4'h4}; lo_n = 4'h1;
    start_read(1'b1);
    wait_valid(100, lat);
    chk("data_lat", lat, 86);
    chk("data_byte", data_out, 8'h41);
    step();

`ifndef LCD_BUSY_POLL_EN
    // address read 8,A with strobe timing measured from the pins
    up_seq = '{4'h8, 4'h8, 4'h8, 4'h8}; lo_n = 4'hA;
    start_read(1'b0);
    lat = -1; prev_e = 1'b0; edges.delete();
    got_byte = 8'h00; got_bf = 1'b0; got_addr = 7'h00;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (lcd_e !== prev_e) begin
        edges.push_back(i);
        prev_e = lcd_e;
      end
      if (valid === 1'b1 && lat < 0) begin
        lat = i; got_byte = data_out; got_bf = busy_flag; got_addr = addr;
      end
    end
    chk("addr_lat", lat, 86);
    chk("addr_byte", got_byte, 8'h8A);
    chk("addr_bf", got_bf, 1);
    chk("addr_addr", got_addr, 7'h0A);
    chk("e_edge_count", edges.size(), 4);
    if (edges.size() >= 4) begin
      chk("e1_width", edges[1] - edges[0], 14);
      chk("e_gap", edges[2] - edges[1], 50);
      chk("e2_width", edges[3] - edges[2], 14);
    end
    step();
`else
    // busy poll: BF 1,1,0 over three attempts -> one valid after the third read
    up_seq = '{4'h8, 4'h8, 4'h0, 4'h0}; lo_n = 4'h5;
    start_read(1'b0);
    wait_valid(400, lat);
    chk("poll_lat", lat, 2 * 85 + 86);
    chk("poll_byte", data_out, 8'h05);
    chk("poll_bf", busy_flag, 0);
    chk("poll_to", poll_timeout, 0);
    step();
`endif

    // stray starts during a read, then a back-to-back read
    up_seq = '{4'h8, 4'h8, 4'h8, 4'h8}; lo_n = 4'hA;
    start_read(1'b1);
    nv = 0; v1 = 0;
    for (int i = 1; i <= 86; i++) begin
      start = (i == 10 || i == 40);
      @(negedge clk);
      if (valid === 1'b1) begin
        nv++; v1 = cyc;
      end
      step();
    end
    start = 1'b0;
    chk("one_valid", nv, 1);
    chk("ready_first_idle", ready, 1);
    start_read(1'b1);
    wait_valid(100, lat);
    v2 = cyc;
    chk("b2b_period", v2 - v1, 87);
    step();

    // enable low during GAP aborts and clears, then a normal read
    up_seq = '{4'h3, 4'h3, 4'h3, 4'h3}; lo_n = 4'h7;
    start_read(1'b1);
    repeat (29) step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    @(negedge clk);
    chk("en_ready", ready, 1);
    chk("en_rw", lcd_rw, 0);
    chk("en_data", data_out, 0);
    step();
    start_read(1'b1);
    wait_valid(100, lat);
    chk("en_lat", lat, 86);
    chk("en_byte", data_out, 8'h37);
    step();

    // reset on the 5th E-high cycle of the upper nibble
    start_read(1'b1);
    repeat (9) step();
    @(negedge clk);
    chk("e_before_rst", lcd_e, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_e", lcd_e, 0);
    chk("rst_mid_rw", lcd_rw, 0);
    chk("rst_mid_ready", ready, 1);
    chk("rst_mid_data", data_out, 0);
    nv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid === 1'b1) nv++;
    end
    chk("rst_no_valid", nv, 0);
    step();

    // random traffic with occasional aborts
    rand_nib = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      rs_sel = 1'($urandom);
      enable = ($urandom_range(0, 599) != 0);
      reset  = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0; enable = 1'b1; start = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_read_fsm.md
Name: lcd_read_fsm

Overview:
Read-side counterpart of the LCD command sender. It runs one HD44780-style 4-bit read transaction (lcd_rw=1): it raises E twice, samples the upper and then the lower nibble from the LCD data bus, and assembles a byte. It serves busy-flag/address reads (rs=0) and data-RAM reads (rs=1). It sits inside the LCD controller next to the command sender; top level muxes lcd_e/lcd_rs/lcd_rw and tri-states sf_d using sf_d_oe.

Parameters:
SETUP_CYCLES, 5, cycles rs/rw are stable before E rises (100 ns @ 50 MHz)
E_HIGH_CYCLES, 14, cycles E stays high per nibble (280 ns @ 50 MHz)
NIBBLE_GAP, 50, cycles E stays low between the two nibbles (1 us @ 50 MHz)
HOLD_CYCLES, 2, cycles rs/rw are held after the second E falls
POLL_LIMIT, 100, maximum read attempts in busy-poll mode (used only with LCD_BUSY_POLL_EN)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
enable  input  1  block enable; low forces IDLE
start  input  1  request a read; accepted only when ready=1
rs_sel  input  1  0 = busy flag/address read, 1 = data read; latched at accept
sf_d_in  input  4  LCD data bus input (sf_d[3:0] as seen by the FPGA)
lcd_e  output  1  LCD enable strobe
lcd_rs  output  1  register select for the current transaction
lcd_rw  output  1  1 during a transaction, 0 otherwise
sf_ce0  output  1  constant 0 (StrataFlash disabled)
sf_d_oe  output  1  1 = top level may drive sf_d; 0 = bus released
ready  output  1  high in IDLE only
valid  output  1  one-cycle pulse when data_out is updated
data_out  output  8  assembled byte {upper, lower}
busy_flag  output  1  data_out[7], qualified by valid when rs_sel was 0
addr  output  7  data_out[6:0]
poll_timeout  output  1  one-cycle pulse (LCD_BUSY_POLL_EN only; else constant 0)

Behaviour:
- Reset, or enable low (enable takes priority): state=IDLE, lcd_e=0, lcd_rs=0, lcd_rw=0, sf_d_oe=1, valid=0, data_out=0, poll_timeout=0, internal counter=0. Both take effect at the next edge from any state, including mid-transaction. An aborted transaction produces no valid.
- All outputs are registered. One internal counter is cleared on every state change.
- IDLE: ready=1. Edge with start=1 latches rs_sel and moves to SETUP. start outside IDLE is ignored, with no queueing.
- SETUP: lcd_rw=1, lcd_rs=latched rs_sel, sf_d_oe=0, lcd_e=0. Lasts SETUP_CYCLES cycles, then UPPER_E.
- UPPER_E: lcd_e=1 for E_HIGH_CYCLES cycles. On the last E-high cycle, sf_d_in is captured into a holding register [7:4]. Then GAP.
- GAP: lcd_e=0 for NIBBLE_GAP cycles, then LOWER_E.
- LOWER_E: same timing as UPPER_E; captures [3:0]. Then HOLD.
- HOLD: lcd_e=0, rs/rw unchanged for HOLD_CYCLES cycles, then DONE.
- DONE (1 cycle): data_out <= holding register, valid=1, lcd_rw=0, sf_d_oe=1. Next state is IDLE.
- Latency: valid is high on cycle 1+SETUP+2*E_HIGH+GAP+HOLD after the accepting edge (86 with defaults). Back-to-back: next start is accepted in the first IDLE cycle, so the minimum period is 87 cycles.
- data_out, busy_flag and addr hold their value between transactions. sf_ce0 is always 0.
- An unreachable state encoding recovers to IDLE with outputs at their reset values.

Optional Feature:
LCD_BUSY_POLL_EN
- Defined: an rs_sel=0 read whose captured bit 7 is 1 does not pulse valid. The block returns to SETUP after HOLD and repeats the read.
  - It stops when BF=0: valid pulses with busy_flag=0.
  - Or it stops after POLL_LIMIT attempts: valid and poll_timeout pulse together, with busy_flag=1.
  - ready stays 0 throughout.
- Undefined: every read ends with a single valid pulse, and poll_timeout is tied to 0.

Test Plan:
- Data read: start with rs_sel=1; bench drives sf_d_in=4 during the first E-high and 1 during the second -> valid at cycle 86, data_out=0x41, lcd_rs=1, lcd_rw=1 and sf_d_oe=0 from cycle 1 to 85.
- Address read: rs_sel=0, nibbles 8 then A -> data_out=0x8A, busy_flag=1, addr=0x0A; E widths exactly 14 cycles with a 50-cycle gap.
- start pulsed at cycles 10 and 40 during a transaction -> ignored, exactly one valid; a second start at the first ready cycle gives valid 87 cycles after the first.
- reset asserted on the 5th cycle of UPPER_E -> lcd_e=0, lcd_rw=0, ready=1 next cycle, no valid, data_out=0x00.
- enable low during GAP -> IDLE next edge; enable high plus start -> full normal read.
- With LCD_BUSY_POLL_EN: upper nibble 8,8,0 on three attempts -> single valid after the 3rd read with busy_flag=0. With POLL_LIMIT=2 and always 8 -> valid plus poll_timeout after the 2nd read.
